// File: rtl/cuppa_wvb_hdr_writer.sv
`default_nettype none
// ============================================================================
//  Module   : cuppa_wvb_hdr_writer
//  Purpose  : Builds one waveform-buffer event header per accepted trigger
//             and writes it, packed as the 87-bit wvb header bundle, into the
//             header FIFO with full back-pressure.
//
//  Ports    : clk           system clock
//             rst           asynchronous active-high reset
//             i_en          arm; new events start only while high
//             i_trig        trigger level (rising edge starts an event)
//             i_trig_src    trigger source code, valid with i_trig
//             i_cnst_run    constant-run mode, latched at event start
//             i_pre_conf    pre-trigger samples, latched at event start
//             i_post_conf   post-trigger samples, latched at event start
//             i_ltc         free-running local time counter
//             i_wr_addr     current waveform buffer write address
//             i_hdr_full    header FIFO full
//             o_hdr_wr_en   header FIFO write strobe (one cycle)
//             o_hdr_data    packed header, qualified by o_hdr_wr_en
//             o_busy        high whenever an event is in progress
//             o_n_drop      saturating count of triggers dropped while busy
//
//  Header packing (LSB first):
//             [47:0] evt_ltc  [62:48] start_addr  [77:63] stop_addr
//             [79:78] trig_src  [80] cnst_run  [86:81] pre_conf
//
//  Revision : 1.0  initial release
// ============================================================================
module cuppa_wvb_hdr_writer #(
   parameter int P_LTC_WIDTH       = 48,
   parameter int P_ADR_WIDTH       = 15,
   parameter int P_PRE_CONF_WIDTH  = 6,
   parameter int P_POST_CONF_WIDTH = 12,
   parameter int P_HDR_WIDTH       = 87,
   parameter int P_DROP_WIDTH      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_en,
   input  logic                         i_trig,
   input  logic [1:0]                   i_trig_src,
   input  logic                         i_cnst_run,
   input  logic [P_PRE_CONF_WIDTH-1:0]  i_pre_conf,
   input  logic [P_POST_CONF_WIDTH-1:0] i_post_conf,
   input  logic [P_LTC_WIDTH-1:0]       i_ltc,
   input  logic [P_ADR_WIDTH-1:0]       i_wr_addr,
   input  logic                         i_hdr_full,
   output logic                         o_hdr_wr_en,
   output logic [P_HDR_WIDTH-1:0]       o_hdr_data,
   output logic                         o_busy,
   output logic [P_DROP_WIDTH-1:0]      o_n_drop
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONT = 2'd1,
      S_POST = 2'd2,
      S_PUSH = 2'd3
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [P_POST_CONF_WIDTH-1:0]  r_cnt;
   logic [P_POST_CONF_WIDTH-1:0]  w_cnt_nxt;
   logic                          r_trig_q;
   logic                          w_trig_edge;
   logic                          w_latch_evt;
   logic                          w_load_hdr;
   logic                          w_wr_en;
   logic                          w_drop;
   logic [P_ADR_WIDTH-1:0]        w_start_addr;

   logic [P_LTC_WIDTH-1:0]        r_evt_ltc;
   logic [P_ADR_WIDTH-1:0]        r_start_addr;
   logic [1:0]                    r_trig_src;
   logic                          r_cnst_run;
   logic [P_PRE_CONF_WIDTH-1:0]   r_pre_conf;
   logic [P_POST_CONF_WIDTH-1:0]  r_post_conf;
   logic [P_HDR_WIDTH-1:0]        r_hdr_data;
   logic [P_DROP_WIDTH-1:0]       r_n_drop;

   assign w_trig_edge  = i_trig & ~r_trig_q;
   // Subtraction is modulo the address width, so starts near 0 wrap to the top.
   assign w_start_addr = i_wr_addr - P_ADR_WIDTH'(i_pre_conf);
   // Any edge outside IDLE is lost, including one coinciding with the write.
   assign w_drop       = w_trig_edge & (r_state != S_IDLE);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch_evt = 1'b0;
      w_load_hdr  = 1'b0;
      w_wr_en     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_trig_edge && i_en) begin
               w_latch_evt = 1'b1;
               if (i_cnst_run) begin
                  w_state_nxt = S_CONT;
               end else begin
                  w_state_nxt = S_POST;
                  w_cnt_nxt   = i_post_conf;
               end
            end
         end
         S_CONT: begin
            if (!i_trig) begin
               w_state_nxt = S_POST;
               w_cnt_nxt   = r_post_conf;
            end
         end
         S_POST: begin
            if (r_cnt == '0) begin
               // Current write address is the stop address for this event.
               w_load_hdr  = 1'b1;
               w_state_nxt = S_PUSH;
            end else begin
               w_cnt_nxt = r_cnt - P_POST_CONF_WIDTH'(1);
            end
         end
         S_PUSH: begin
            if (!i_hdr_full) begin
               w_wr_en     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Event field capture, header assembly and drop counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trig_q     <= 1'b0;
         r_evt_ltc    <= '0;
         r_start_addr <= '0;
         r_trig_src   <= '0;
         r_cnst_run   <= 1'b0;
         r_pre_conf   <= '0;
         r_post_conf  <= '0;
         r_hdr_data   <= '0;
         r_n_drop     <= '0;
      end else begin
         r_trig_q <= i_trig;
         if (w_latch_evt) begin
            r_evt_ltc    <= i_ltc;
            r_start_addr <= w_start_addr;
            r_trig_src   <= i_trig_src;
            r_cnst_run   <= i_cnst_run;
            r_pre_conf   <= i_pre_conf;
            r_post_conf  <= i_post_conf;
         end
         // Header is frozen from here until the next event reaches PUSH,
         // so it stays stable however long the FIFO back-pressures.
         if (w_load_hdr) begin
            r_hdr_data <= {r_pre_conf, r_cnst_run, r_trig_src,
                           i_wr_addr, r_start_addr, r_evt_ltc};
         end
         if (w_drop && (r_n_drop != '1)) begin
            r_n_drop <= r_n_drop + P_DROP_WIDTH'(1);
         end
      end
   end

   assign o_hdr_wr_en = w_wr_en;
   assign o_hdr_data  = r_hdr_data;
   assign o_busy      = (r_state != S_IDLE);
   assign o_n_drop    = r_n_drop;

endmodule
`default_nettype wire

// File: tb/tb_cuppa_wvb_hdr_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cuppa_wvb_hdr_writer
//  Purpose  : Self-checking bench for cuppa_wvb_hdr_writer. Expected headers
//             and their write cycles are queued when a trigger is driven and
//             compared when the DUT strobes the FIFO write.
//             A second instance with a 4-bit drop counter exercises counter
//             saturation within a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cuppa_wvb_hdr_writer;

   localparam int LW = 48;
   localparam int AW = 15;
   localparam int PW = 6;
   localparam int QW = 12;
   localparam int HW = 87;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          en        = 1'b0;
   logic          trig      = 1'b0;
   logic [1:0]    trig_src  = '0;
   logic          cnst_run  = 1'b0;
   logic [PW-1:0] pre_conf  = '0;
   logic [QW-1:0] post_conf = '0;
   logic [LW-1:0] ltc       = '0;
   logic [AW-1:0] wr_addr   = '0;
   logic          hdr_full  = 1'b0;

   logic          hdr_wr_en;
   logic [HW-1:0] hdr_data;
   logic          busy;
   logic [15:0]   n_drop;

   logic          s_wr_en;
   logic [HW-1:0] s_data;
   logic          s_busy;
   logic [3:0]    s_n_drop;

   typedef struct {
      logic [HW-1:0] hdr;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   n_writes = 0;
   int   cyc_cnt  = 0;

   cuppa_wvb_hdr_writer dut (
      .clk         (clk),
      .rst         (rst),
      .i_en        (en),
      .i_trig      (trig),
      .i_trig_src  (trig_src),
      .i_cnst_run  (cnst_run),
      .i_pre_conf  (pre_conf),
      .i_post_conf (post_conf),
      .i_ltc       (ltc),
      .i_wr_addr   (wr_addr),
      .i_hdr_full  (hdr_full),
      .o_hdr_wr_en (hdr_wr_en),
      .o_hdr_data  (hdr_data),
      .o_busy      (busy),
      .o_n_drop    (n_drop)
   );

   cuppa_wvb_hdr_writer #(.P_DROP_WIDTH(4)) dut_small (
      .clk         (clk),
      .rst         (rst),
      .i_en        (en),
      .i_trig      (trig),
      .i_trig_src  (trig_src),
      .i_cnst_run  (cnst_run),
      .i_pre_conf  (pre_conf),
      .i_post_conf (post_conf),
      .i_ltc       (ltc),
      .i_wr_addr   (wr_addr),
      .i_hdr_full  (hdr_full),
      .o_hdr_wr_en (s_wr_en),
      .o_hdr_data  (s_data),
      .o_busy      (s_busy),
      .o_n_drop    (s_n_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Scoreboard consumer: every write must match the oldest expected header
   // and land on the expected cycle.
   always @(negedge clk) begin
      if (hdr_wr_en === 1'b1) begin
         n_writes++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d data=%h required=no write", cyc_cnt, hdr_data);
         end else begin
            mon_e = sb.pop_front();
            if (hdr_data !== mon_e.hdr) begin
               errors++;
               $display("FAIL hdr_data got=%h required=%h", hdr_data, mon_e.hdr);
            end
            checks++;
            if (cyc_cnt != mon_e.cyc) begin
               errors++;
               $display("FAIL write_cycle got=%0d required=%0d", cyc_cnt, mon_e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_addr = wr_addr + 1'b1;
      ltc     = ltc + 48'd1;
   endtask

   task automatic expect_hdr(input logic [LW-1:0] l, input logic [AW-1:0] st,
                             input logic [AW-1:0] sp, input logic [1:0] s,
                             input logic c, input logic [PW-1:0] p, input int cyc);
      exp_t e;
      e.hdr = {p, c, s, sp, st, l};
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         step();
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      step();
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (hdr_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b required=0", hdr_wr_en); end
      checks++; if (hdr_data !== '0) begin errors++; $display("FAIL reset_hdr_data got=%h required=0", hdr_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
      checks++; if (n_drop !== 16'd0) begin errors++; $display("FAIL reset_n_drop got=%h required=0", n_drop); end
      rst = 1'b0;
      en  = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int w0;
      w0 = n_writes;
      step();
      pre_conf = 6'd4; post_conf = 12'd10; cnst_run = 1'b0; trig_src = 2'b10;
      wr_addr = 15'h0100; ltc = 48'h123456789ABC; trig = 1'b1;
      expect_hdr(48'h123456789ABC, 15'h00FC, 15'h010B, 2'b10, 1'b0, 6'd4, cyc_cnt + 12);
      step();
      trig = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b required=1", busy); end
      step();
      pre_conf = '0; post_conf = '0; trig_src = '0;
      drain(40);
      checks++; if (n_writes != w0 + 1) begin errors++; $display("FAIL basic_write_count got=%0d required=%0d", n_writes - w0, 1); end
   endtask

   task automatic test_wrap();
      step();
      pre_conf = 6'd8; post_conf = 12'd2; wr_addr = 15'h0003; ltc = 48'h00000000000A;
      trig_src = 2'b01; trig = 1'b1;
      expect_hdr(48'h00000000000A, 15'h7FFB, 15'h0006, 2'b01, 1'b0, 6'd8, cyc_cnt + 4);
      step();
      trig = 1'b0;
      drain(20);
      step();
      pre_conf = 6'd0; post_conf = 12'd3; wr_addr = 15'h7FFE; ltc = 48'h0000000000B0;
      trig_src = 2'b11; trig = 1'b1;
      expect_hdr(48'h0000000000B0, 15'h7FFE, 15'h0002, 2'b11, 1'b0, 6'd0, cyc_cnt + 5);
      step();
      trig = 1'b0;
      drain(20);
   endtask

   task automatic test_cnst_run();
      int w0;
      w0 = n_writes;
      step();
      cnst_run = 1'b1; pre_conf = 6'd2; post_conf = 12'd0; wr_addr = 15'h0200;
      ltc = 48'h000000005000; trig_src = 2'b01; trig = 1'b1;
      expect_hdr(48'h000000005000, 15'h01FE, 15'h0233, 2'b01, 1'b1, 6'd2, cyc_cnt + 52);
      step();
      cnst_run = 1'b0; pre_conf = 6'd5;
      repeat (48) step();
      step();
      trig = 1'b0;
      drain(10);
      repeat (5) step();
      checks++; if (n_writes != w0 + 1) begin errors++; $display("FAIL cnst_write_count got=%0d required=%0d", n_writes - w0, 1); end
   endtask

   task automatic test_back_to_back();
      int t0;
      step();
      pre_conf = 6'd1; post_conf = 12'd2; cnst_run = 1'b0; trig_src = 2'b10;
      ltc = 48'hFFFFFFFFFFF0; wr_addr = 15'h1000; hdr_full = 1'b1; trig = 1'b1;
      t0 = cyc_cnt;
      expect_hdr(48'hFFFFFFFFFFF0, 15'h0FFF, 15'h1003, 2'b10, 1'b0, 6'd1, t0 + 24);
      step();
      trig = 1'b0;
      for (int c = 2; c <= 23; c++) begin
         step();
         trig = (c == 6 || c == 10 || c == 14);
         #1;
         if (c >= 4) begin
            checks++;
            if (hdr_wr_en !== 1'b0) begin errors++; $display("FAIL full_hold_wr_en cyc=%0d got=%b required=0", c, hdr_wr_en); end
         end
      end
      // Release full; an edge on the write cycle itself is dropped.
      step();
      hdr_full = 1'b0; trig = 1'b1;
      step();
      trig = 1'b0;
      step();
      pre_conf = 6'd0; post_conf = 12'd1; trig = 1'b1;
      expect_hdr(ltc, wr_addr, wr_addr + 15'd2, 2'b10, 1'b0, 6'd0, cyc_cnt + 3);
      step();
      trig = 1'b0;
      drain(20);
      checks++; if (n_drop !== 16'd4) begin errors++; $display("FAIL bp_n_drop got=%0d required=4", n_drop); end
   endtask

   task automatic test_reset_mid();
      int w0;
      w0 = n_writes;
      step();
      pre_conf = 6'd3; post_conf = 12'd10; trig_src = 2'b01; wr_addr = 15'h0400; trig = 1'b1;
      step();
      trig = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      checks++; if (hdr_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%b required=0", hdr_wr_en); end
      checks++; if (hdr_data !== '0) begin errors++; $display("FAIL rstmid_hdr_data got=%h required=0", hdr_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b required=0", busy); end
      checks++; if (n_drop !== 16'd0) begin errors++; $display("FAIL rstmid_n_drop got=%0d required=0", n_drop); end
      step();
      step();
      rst = 1'b0;
      repeat (15) step();
      checks++; if (n_writes != w0) begin errors++; $display("FAIL rstmid_writes got=%0d required=0", n_writes - w0); end
      step();
      pre_conf = 6'd3; post_conf = 12'd5; wr_addr = 15'h0500; ltc = 48'h0BEEF0000001; trig = 1'b1;
      expect_hdr(48'h0BEEF0000001, 15'h04FD, 15'h0506, 2'b01, 1'b0, 6'd3, cyc_cnt + 7);
      step();
      trig = 1'b0;
      drain(20);
   endtask

   task automatic test_drop_sat();
      int t0;
      logic [HW-1:0] h;
      step();
      pre_conf = 6'd0; post_conf = 12'd0; trig_src = 2'b11; wr_addr = 15'h0600;
      ltc = 48'h000000C0FFEE; hdr_full = 1'b1; trig = 1'b1;
      t0 = cyc_cnt;
      h  = {6'd0, 1'b0, 2'b11, 15'h0601, 15'h0600, 48'h000000C0FFEE};
      expect_hdr(48'h000000C0FFEE, 15'h0600, 15'h0601, 2'b11, 1'b0, 6'd0, t0 + 42);
      for (int i = 0; i < 20; i++) begin
         step(); trig = 1'b0;
         step(); trig = 1'b1;
      end
      step();
      trig = 1'b0;
      #1;
      checks++; if (n_drop !== 16'd20) begin errors++; $display("FAIL drop_count got=%0d required=20", n_drop); end
      checks++; if (s_n_drop !== 4'hF) begin errors++; $display("FAIL drop_saturate got=%h required=f", s_n_drop); end
      checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL small_busy got=%b required=1", s_busy); end
      checks++; if (s_wr_en !== 1'b0) begin errors++; $display("FAIL small_wr_en got=%b required=0", s_wr_en); end
      checks++; if (s_data !== h) begin errors++; $display("FAIL small_hdr got=%h required=%h", s_data, h); end
      step();
      hdr_full = 1'b0;
      drain(10);
   endtask

   task automatic test_en_gating();
      int w0;
      w0 = n_writes;
      step(); en = 1'b0; trig = 1'b1;
      step(); trig = 1'b0;
      step(); trig = 1'b1;
      step(); trig = 1'b0;
      step();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en0_busy got=%b required=0", busy); end
      checks++; if (n_drop !== 16'd20) begin errors++; $display("FAIL en0_n_drop got=%0d required=20", n_drop); end
      repeat (10) step();
      checks++; if (n_writes != w0) begin errors++; $display("FAIL en0_writes got=%0d required=0", n_writes - w0); end
      // Disarming right after the trigger must not cancel the event.
      step();
      en = 1'b1; pre_conf = 6'd0; post_conf = 12'd4; wr_addr = 15'h0700;
      ltc = 48'h000000000777; trig_src = 2'b00; trig = 1'b1;
      expect_hdr(48'h000000000777, 15'h0700, 15'h0705, 2'b00, 1'b0, 6'd0, cyc_cnt + 6);
      step();
      en = 1'b0; trig = 1'b0;
      drain(20);
      checks++; if (n_writes != w0 + 1) begin errors++; $display("FAIL en_mid_writes got=%0d required=1", n_writes - w0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_cnst_run();
      test_back_to_back();
      test_reset_mid();
      test_drop_sat();
      test_en_gating();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/cuppa_wvb_hdr_writer.md
Name: cuppa_wvb_hdr_writer

Overview: Generates one waveform-buffer event header per trigger and writes it, packed as the 87-bit cuppa wvb header bundle, into the header FIFO. It sits beside the waveform buffer writer and follows the same trigger and write-address stream. It captures the event LTC, start/stop buffer addresses, trigger source and run configuration, then performs a single-cycle FIFO write with full back-pressure. The header readout path unpacks this bundle on the far side of the FIFO.

Parameters:
P_LTC_WIDTH, 48, LTC / evt_ltc width
P_ADR_WIDTH, 15, waveform buffer address width
P_PRE_CONF_WIDTH, 6, pre-trigger sample count width
P_POST_CONF_WIDTH, 12, post-trigger sample count width
P_HDR_WIDTH, 87, packed width; must equal P_LTC_WIDTH+2*P_ADR_WIDTH+2+1+P_PRE_CONF_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  arm; new events start only while high
trig  in  1  trigger level, sampled each clk
trig_src  in  2  trigger source code, valid with trig
cnst_run  in  1  constant-run mode, latched at event start
pre_conf  in  P_PRE_CONF_WIDTH  pre-trigger samples, latched at event start
post_conf  in  P_POST_CONF_WIDTH  post-trigger samples, latched at event start
ltc  in  P_LTC_WIDTH  free-running local time counter
wr_addr  in  P_ADR_WIDTH  current waveform buffer write address
hdr_full  in  1  header FIFO full
hdr_wr_en  out  1  header FIFO write strobe, one cycle
hdr_data  out  P_HDR_WIDTH  packed header
busy  out  1  high in any state except IDLE
n_drop  out  16  count of triggers dropped while busy, saturating

Behaviour:
- Reset (async): state=IDLE, hdr_wr_en=0, hdr_data=0, busy=0, n_drop=0, trig_q=0, all latched fields=0. A reset mid-event discards the event; no partial header is written.
- Trigger edge: trig_edge = trig & ~trig_q, where trig_q is trig registered each clk.
- Packing of hdr_data, LSB first:
  - [47:0] evt_ltc
  - [62:48] start_addr
  - [77:63] stop_addr
  - [79:78] trig_src
  - [80] cnst_run
  - [86:81] pre_conf
- IDLE:
  - On trig_edge with en=1 at cycle T, latch:
    - evt_ltc = ltc(T)
    - start_addr = (wr_addr(T) - pre_conf) mod 2^P_ADR_WIDTH
    - trig_src, cnst_run, pre_conf, post_conf
  - Next state: CONT if cnst_run=1, else POST with cnt=post_conf.
  - With en=0, edges are ignored and not counted.
- CONT: stay while trig=1. On the first cycle with trig=0, go to POST with cnt=post_conf latched.
- POST:
  - If cnt==0: stop_addr = wr_addr this cycle; go to PUSH.
  - Otherwise cnt decrements by 1.
- PUSH:
  - If hdr_full=0: hdr_wr_en=1 for exactly this cycle with hdr_data valid; next state is IDLE.
  - If hdr_full=1: hold all fields, hdr_wr_en=0, remain in PUSH indefinitely.
- Latency (cnst_run=0, edge at T): POST occupies T+1..T+1+P, stop sampled at T+1+P, and hdr_wr_en is asserted at T+2+P if not full.
- Drops: trig_edge in CONT, POST or PUSH increments n_drop (saturates at 16'hFFFF) and does not disturb the current event. An edge on the same cycle PUSH writes is also dropped. IDLE accepts edges only from the following cycle.
- en deassertion mid-event: the current event still completes and writes its header.
- Address wrap: start_addr subtraction and the stop_addr capture both wrap mod 2^P_ADR_WIDTH. No range check is applied.
- hdr_data holds its last value between writes. Only hdr_wr_en qualifies it.

Test Plan:
- Basic event: reset; en=1, cnst_run=0, pre_conf=4, post_conf=10, wr_addr increments each clk, edge at wr_addr=0x0100, ltc=0x123456789ABC -> one hdr_wr_en 12 cycles later with evt_ltc=0x123456789ABC, start=0x00FC, stop=0x010B, cnst_run=0, pre_conf=4, trig_src as driven.
- Start wrap: pre_conf=8, edge at wr_addr=0x0003 -> start_addr=0x7FFB. Stop wrap: wr_addr 0x7FFE, post_conf=3 -> stop_addr=0x0002.
- Constant run: cnst_run=1, post_conf=0, trig held high 50 cycles from wr_addr=0x0200 -> stop_addr=0x0233, cnst_run bit=1, exactly one write.
- Back-pressure: hdr_full=1 when PUSH is reached, held 20 cycles, with 3 trigger edges during the hold -> no write while full; one write on the first not-full cycle with fields unchanged; n_drop=3.
- Reset mid-event: assert rst during POST -> no hdr_wr_en, outputs zero, busy=0. The next trigger produces a correct header.
- n_drop saturation and en gating: force 65540 drops -> n_drop=0xFFFF. Edges with en=0 in IDLE -> no event and no n_drop change.
